// File: rtl/sha256.sv
// Streaming SHA-256: absorbs a byte stream into 512-bit blocks, pads the final block(s)
// and compresses one round per clock, emitting a one-cycle digest pulse per message.
module sha256 (
  input  logic         clk,
  input  logic         rst,
  output logic         tready,
  input  logic         tvalid,
  input  logic         tlast,
  input  logic [31:0]  tid,
  input  logic [7:0]   tdata,
  output logic         ovalid,
  output logic [31:0]  oid,
  output logic [60:0]  olen,
  output logic [255:0] osha
);

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {ABSORB, COMPRESS, PAD, DONE} state_t;
  // Which kind of block the next compression belongs to.
  typedef enum logic [1:0] {PH_MSG, PH_PAD1, PH_PAD2, PH_FINAL} phase_t;

  state_t      state, state_n;
  phase_t      phase;
  logic [31:0] w     [0:15];
  logic [31:0] pad_w [0:15];
  logic [31:0] hv    [0:7];
  logic [31:0] v     [0:7];
  logic [31:0] sum   [0:7];
  logic [60:0] cnt;
  logic [6:0]  rnd;
  logic [31:0] id;
  logic        in_msg;
  logic        accept;
  logic        fits;
  logic [5:0]  idx;
  logic [63:0] bitlen;
  logic [31:0] t1, t2, w_next;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  assign accept = tvalid & tready;
  assign idx    = cnt[5:0];
  assign bitlen = {cnt, 3'b000};
  assign fits   = (phase == PH_PAD2) || (idx < 6'd56);

  assign t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[rnd[5:0]] + w[0];
  assign t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
  assign w_next = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
                + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];

  always_comb begin
    for (int i = 0; i < 8; i++) sum[i] = hv[i] + v[i];
  end

  // Padding block: bytes from the current fill level onward become 0x80 then zeros;
  // a length-only second block clears everything.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    for (int i = 0; i < 16; i++) pad_w[i] = w[i];
    for (int wi = 0; wi < 16; wi++) begin
      for (int bi = 0; bi < 4; bi++) begin
        if (phase == PH_PAD2 || 6'(wi * 4 + bi) >= idx)
          pad_w[wi][8*(3-bi) +: 8] = (phase == PH_PAD1 && 6'(wi * 4 + bi) == idx) ? 8'h80 : 8'h00;
      end
    end
    if (fits) begin
      pad_w[14] = bitlen[63:32];
      pad_w[15] = bitlen[31:0];
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ABSORB:   if (accept) begin
                  if (idx == 6'd63) state_n = COMPRESS;
                  else if (tlast)   state_n = PAD;
                end
      PAD:      state_n = COMPRESS;
      COMPRESS: if (rnd == 7'd64) begin
                  case (phase)
                    PH_FINAL: state_n = DONE;
                    PH_MSG:   state_n = ABSORB;
                    default:  state_n = PAD;
                  endcase
                end
      DONE:     state_n = ABSORB;
      default:  state_n = ABSORB;
    endcase
  end

  // NOTE: the block buffer and working variables are always loaded before use, so they
  // carry no reset; keeping them out of the reset block avoids turning rst into an enable.
  always_ff @(posedge clk) begin
    if (accept)
      w[idx[5:2]][{~idx[1:0], 3'b000} +: 8] <= tdata;
    else if (state == PAD)
      w <= pad_w;
    else if (state == COMPRESS && rnd < 7'd64) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_next;
    end

    if (state != COMPRESS)
      v <= hv;
    else if (rnd < 7'd64) begin
      v[0] <= t1 + t2;
      v[1] <= v[0];
      v[2] <= v[1];
      v[3] <= v[2];
      v[4] <= v[3] + t1;
      v[5] <= v[4];
      v[6] <= v[5];
      v[7] <= v[6];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ABSORB;
      phase  <= PH_MSG;
      tready <= 1'b1;
      ovalid <= 1'b0;
      oid    <= '0;
      olen   <= '0;
      osha   <= '0;
      cnt    <= '0;
      rnd    <= '0;
      id     <= '0;
      in_msg <= 1'b0;
      hv     <= IV;
    end else begin
      state  <= state_n;
      tready <= (state_n == ABSORB);
      ovalid <= (state_n == DONE);
      rnd    <= (state == COMPRESS) ? rnd + 7'd1 : 7'd0;
      if (accept) begin
        cnt    <= cnt + 61'd1;
        in_msg <= 1'b1;
        if (!in_msg) id <= tid;
        if (tlast)   phase <= PH_PAD1;
      end
      if (state == PAD) phase <= fits ? PH_FINAL : PH_PAD2;
      if (state == COMPRESS && rnd == 7'd64) begin
        if (phase == PH_FINAL) begin
          osha   <= {sum[0], sum[1], sum[2], sum[3], sum[4], sum[5], sum[6], sum[7]};
          oid    <= id;
          olen   <= cnt;
          cnt    <= '0;
          in_msg <= 1'b0;
          phase  <= PH_MSG;
          hv     <= IV;
        end else begin
          hv <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256.sv
// Randomized scoreboard bench for sha256: a FIPS 180-4 byte-level model predicts each
// digest; a negedge monitor pops and compares on every ovalid pulse.
module tb_sha256;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IVT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [255:0] SHA_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] SHA_A   = 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
  localparam logic [255:0] SHA_56  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam string STR_56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

  typedef struct {
    logic [31:0]  id;
    logic [60:0]  len;
    logic [255:0] sha;
    int           t_last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         tready, tvalid, tlast, ovalid;
  logic [31:0]  tid, oid;
  logic [7:0]   tdata;
  logic [60:0]  olen;
  logic [255:0] osha;

  exp_t         sb[$];
  logic [7:0]   msg_q[$];
  int           compared = 0;
  int           mismatched = 0;
  int           cyc = 0;
  logic         prev_ov = 1'b0;
  logic [31:0]  last_id = '0;
  logic [60:0]  last_len = '0;
  logic [255:0] last_sha = '0;

  sha256 dut (
    .clk(clk), .rst(rst), .tready(tready), .tvalid(tvalid), .tlast(tlast), .tid(tid),
    .tdata(tdata), .ovalid(ovalid), .oid(oid), .olen(olen), .osha(osha)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference digest of msg_q: pad the byte list, then run every 64-byte chunk.
  function automatic logic [255:0] sha_model();
    logic [7:0]  m[$];
    logic [31:0] hs[8];
    logic [31:0] wt[64];
    logic [31:0] va[8];
    logic [31:0] x1, x2;
    logic [63:0] bits;
    m = msg_q;
    bits = 64'(msg_q.size()) << 3;
    m.push_back(8'h80);
    while (m.size() % 64 != 56) m.push_back(8'h00);
    for (int i = 7; i >= 0; i--) m.push_back(bits[8*i +: 8]);
    hs = IVT;
    for (int blk = 0; blk < m.size() / 64; blk++) begin
      for (int t = 0; t < 16; t++)
        wt[t] = {m[blk*64+4*t], m[blk*64+4*t+1], m[blk*64+4*t+2], m[blk*64+4*t+3]};
      for (int t = 16; t < 64; t++)
        wt[t] = (ror(wt[t-2], 17) ^ ror(wt[t-2], 19) ^ (wt[t-2] >> 10)) + wt[t-7]
              + (ror(wt[t-15], 7) ^ ror(wt[t-15], 18) ^ (wt[t-15] >> 3)) + wt[t-16];
      va = hs;
      for (int t = 0; t < 64; t++) begin
        x1 = va[7] + (ror(va[4], 6) ^ ror(va[4], 11) ^ ror(va[4], 25))
           + ((va[4] & va[5]) ^ (~va[4] & va[6])) + KT[t] + wt[t];
        x2 = (ror(va[0], 2) ^ ror(va[0], 13) ^ ror(va[0], 22))
           + ((va[0] & va[1]) ^ (va[0] & va[2]) ^ (va[1] & va[2]));
        va[7] = va[6]; va[6] = va[5]; va[5] = va[4]; va[4] = va[3] + x1;
        va[3] = va[2]; va[2] = va[1]; va[1] = va[0]; va[0] = x1 + x2;
      end
      for (int i = 0; i < 8; i++) hs[i] = hs[i] + va[i];
    end
    return {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]};
  endfunction

  task automatic load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s.getc(i));
  endtask

  task automatic load_rand(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  // Offers the first n bytes of msg_q; tid is randomised after the first byte.
  task automatic send(input logic [31:0] id, input logic [255:0] exp_sha, input bit bubbles,
                      input bit with_last, input int n);
    bit   acc;
    int   waited;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (bubbles && $urandom_range(1) == 1) begin
        tvalid = 1'b0;
        tdata  = 8'($urandom);
        @(posedge clk); #1;
      end
      tvalid = 1'b1;
      tdata  = msg_q[i];
      tlast  = with_last && (i == n - 1);
      tid    = (i == 0) ? id : $urandom;
      acc    = 1'b0;
      waited = 0;
      while (!acc) begin
        acc = tready;
        @(posedge clk); #1;
        if (!acc) begin
          waited++;
          if (waited > 1000) begin
            $display("FAIL tready_timeout: no tready after %0d cycles at byte %0d", waited, i);
            $fatal(1, "tready never returned");
          end
        end
      end
      if (tlast) begin
        e.id = id; e.len = 61'(msg_q.size()); e.sha = exp_sha; e.t_last = cyc;
        sb.push_back(e);
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    check("rst_async_tready", tready, 1);
    check("rst_async_ovalid", ovalid, 0);
    check("rst_async_oid", oid, 0);
    check("rst_async_olen", olen, 0);
    check("rst_async_osha", osha, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_id = '0; last_len = '0; last_sha = '0;
    @(posedge clk); #1;
    check("post_rst_tready", tready, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ovalid) begin
      check("ovalid_single_cycle", prev_ov, 0);
      check("tready_low_at_ovalid", tready, 0);
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_ovalid: got oid=%h olen=%0d with nothing expected", oid, olen);
      end else begin
        e = sb.pop_front();
        check("oid", oid, e.id);
        check("olen", olen, e.len);
        check("osha", osha, e.sha);
        check("latency_le_160", (cyc - e.t_last) <= 160, 1);
        last_id = e.id; last_len = e.len; last_sha = e.sha;
      end
    end
    prev_ov = ovalid;
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int lens[9] = '{55, 57, 63, 64, 65, 119, 120, 128, 200};
    logic [255:0] exp_sha;
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; tid = '0; tdata = '0;
    #3;
    check("reset_tready", tready, 1);
    check("reset_ovalid", ovalid, 0);
    check("reset_olen", olen, 0);
    check("reset_osha", osha, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reference vectors, first without bubbles, then back-to-back with bubbles.
    for (int pass = 0; pass < 2; pass++) begin
      load_str("abc"); send(32'h111, SHA_ABC, pass == 1, 1'b1, msg_q.size());
      load_str("a");   send(32'h222, SHA_A,   pass == 1, 1'b1, msg_q.size());
      load_str(STR_56); send(32'h333, SHA_56, pass == 1, 1'b1, msg_q.size());
    end

    // Boundary and multi-block lengths, plus a few random ones, against the model.
    foreach (lens[i]) begin
      load_rand(lens[i]);
      exp_sha = sha_model();
      send($urandom, exp_sha, 1'b1, 1'b1, msg_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      load_rand($urandom_range(150, 1));
      exp_sha = sha_model();
      send($urandom, exp_sha, $urandom_range(1) == 1, 1'b1, msg_q.size());
    end
    wait_drain();

    // Abort mid-message: 60 of 100 bytes, reset, then a fresh message.
    load_rand(100);
    send(32'hdead, '0, 1'b1, 1'b0, 60);
    pulse_reset();
    load_str("abc"); send(32'h111, SHA_ABC, 1'b1, 1'b1, msg_q.size());
    wait_drain();

    // Abort mid-compression of a full first block.
    load_rand(100);
    send(32'hbeef, '0, 1'b0, 1'b0, 64);
    check("tready_low_compress", tready, 0);
    repeat (20) @(posedge clk);
    #1;
    pulse_reset();
    load_str("a"); send(32'h222, SHA_A, 1'b0, 1'b1, msg_q.size());
    wait_drain();

    repeat (30) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 0);
    check("hold_oid", oid, last_id);
    check("hold_olen", olen, last_len);
    check("hold_osha", osha, last_sha);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
